bp_update_sched: RTL and testbench

- Sequences branch-resolution updates into the predictor after commit.
- Buffers retired-branch updates in a small FIFO.
- Runs a read-modify-write of the 2-bit counters in the local (2-level) PHT and the gshare PHT. Both PHTs are single-port SRAMs shared with front-end lookup, which always has priority.
- After each write-back, emits a one-cycle update pulse to the tournament chooser (branch_we / misprediction / predictor_used).

---
 rtl/bp_update_sched.sv | 214 +++++++++++++++++++++
 tb/tb_bp_update_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_sched.sv
// Post-commit branch predictor update scheduler: queues retired-branch updates and
// read-modify-writes the local and gshare 2-bit counters, then strobes the chooser.
// Optional macro BP_UPD_STATS_EN adds stat_updates / stat_mispredicts counters.
module bp_update_sched #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PHT_IDX_W   = 10,
    parameter int GHR_W       = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [31:0]          upd_pc,
    input  logic [GHR_W-1:0]     upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    input  logic                 upd_pred_used,
    input  logic                 fe_lookup,
    output logic                 pht_en,
    output logic                 pht_we,
    output logic [PHT_IDX_W-1:0] pht_local_addr,
    output logic [PHT_IDX_W-1:0] pht_gshare_addr,
    output logic [1:0]           pht_local_wdata,
    output logic [1:0]           pht_gshare_wdata,
    input  logic [1:0]           pht_local_rdata,
    input  logic [1:0]           pht_gshare_rdata,
    output logic                 chooser_we,
    output logic                 chooser_mispredict,
    output logic                 chooser_pred_used,
    output logic                 busy
`ifdef BP_UPD_STATS_EN
    ,
    output logic [31:0]          stat_updates,
    output logic [31:0]          stat_mispredicts
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PHT_IDX_W-1:0] pc_idx;
        logic [GHR_W-1:0]     ghr;
        logic                 taken;
        logic                 mispredict;
        logic                 pred_used;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WAIT = 2'd2,
        WR   = 2'd3
    } state_t;

    entry_t               fifo_mem [QUEUE_DEPTH];
    entry_t               entry_in;
    entry_t               head;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic                 upd_ready_reg;
    logic                 push;
    logic                 pop;

    state_t               state_reg;
    state_t               state_next;
    logic [PHT_IDX_W-1:0] local_idx_reg;
    logic [PHT_IDX_W-1:0] gshare_idx_reg;
    logic                 taken_reg;
    logic                 mispredict_reg;
    logic                 pred_used_reg;
    logic [1:0]           local_wdata_reg;
    logic [1:0]           gshare_wdata_reg;

    // Only the word-index bits of the PC select a counter.
    logic                 unused_pc_bits;
    assign unused_pc_bits = ^{upd_pc[31:PHT_IDX_W+2], upd_pc[1:0]};

    function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
        if (t)
            return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else
            return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    assign entry_in = '{pc_idx:     upd_pc[PHT_IDX_W+1:2],
                        ghr:        upd_ghr,
                        taken:      upd_taken,
                        mispredict: upd_mispredict,
                        pred_used:  upd_pred_used};
    assign head       = fifo_mem[rd_ptr_reg];
    // upd_ready is registered, so a full FIFO refuses entries even if a pop coincides.
    assign push       = upd_valid & upd_ready_reg;
    assign pop        = (state_reg == IDLE) && (count_reg != '0);
    assign count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= entry_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            upd_ready_reg <= 1'b1;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg     <= count_next;
            upd_ready_reg <= (count_next != CNT_W'(QUEUE_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            local_idx_reg    <= '0;
            gshare_idx_reg   <= '0;
            taken_reg        <= 1'b0;
            mispredict_reg   <= 1'b0;
            pred_used_reg    <= 1'b0;
            local_wdata_reg  <= 2'd0;
            gshare_wdata_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                local_idx_reg  <= head.pc_idx;
                gshare_idx_reg <= head.pc_idx ^ PHT_IDX_W'(head.ghr);
                taken_reg      <= head.taken;
                mispredict_reg <= head.mispredict;
                pred_used_reg  <= head.pred_used;
            end
            if (state_reg == WAIT) begin
                local_wdata_reg  <= next_ctr(pht_local_rdata, taken_reg);
                gshare_wdata_reg <= next_ctr(pht_gshare_rdata, taken_reg);
            end
        end
    end

    // Front-end lookup owns the PHTs whenever fe_lookup is high; we simply retry.
    always_comb begin
        state_next         = state_reg;
        pht_en             = 1'b0;
        pht_we             = 1'b0;
        pht_local_addr     = '0;
        pht_gshare_addr    = '0;
        pht_local_wdata    = 2'd0;
        pht_gshare_wdata   = 2'd0;
        chooser_we         = 1'b0;
        chooser_mispredict = 1'b0;
        chooser_pred_used  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0)
                    state_next = RD;
            end
            RD: begin
                if (!fe_lookup) begin
                    pht_en          = 1'b1;
                    pht_local_addr  = local_idx_reg;
                    pht_gshare_addr = gshare_idx_reg;
                    state_next      = WAIT;
                end
            end
            WAIT: begin
                state_next = WR;
            end
            WR: begin
                pht_local_addr   = local_idx_reg;
                pht_gshare_addr  = gshare_idx_reg;
                pht_local_wdata  = local_wdata_reg;
                pht_gshare_wdata = gshare_wdata_reg;
                if (!fe_lookup) begin
                    pht_en             = 1'b1;
                    pht_we             = 1'b1;
                    chooser_we         = 1'b1;
                    chooser_mispredict = mispredict_reg;
                    chooser_pred_used  = pred_used_reg;
                    state_next         = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign upd_ready = upd_ready_reg;
    assign busy      = (count_reg != '0) | (state_reg != IDLE);

`ifdef BP_UPD_STATS_EN
    logic [31:0] stat_updates_reg;
    logic [31:0] stat_mispredicts_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (chooser_we) begin
            stat_updates_reg <= stat_updates_reg + 32'd1;
            if (chooser_mispredict)
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
        end
    end

    assign stat_updates     = stat_updates_reg;
    assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched with a small behavioural model of the two PHT SRAMs.
module tb_bp_update_sched;

    logic        clk;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [9:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        upd_pred_used;
    logic        fe_lookup;
    logic        pht_en;
    logic        pht_we;
    logic [9:0]  pht_local_addr;
    logic [9:0]  pht_gshare_addr;
    logic [1:0]  pht_local_wdata;
    logic [1:0]  pht_gshare_wdata;
    logic [1:0]  pht_local_rdata;
    logic [1:0]  pht_gshare_rdata;
    logic        chooser_we;
    logic        chooser_mispredict;
    logic        chooser_pred_used;
    logic        busy;
`ifdef BP_UPD_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    bp_update_sched #(.QUEUE_DEPTH(4), .PHT_IDX_W(10), .GHR_W(10)) dut (
        .clk                (clk),
        .rst                (rst),
        .upd_valid          (upd_valid),
        .upd_ready          (upd_ready),
        .upd_pc             (upd_pc),
        .upd_ghr            (upd_ghr),
        .upd_taken          (upd_taken),
        .upd_mispredict     (upd_mispredict),
        .upd_pred_used      (upd_pred_used),
        .fe_lookup          (fe_lookup),
        .pht_en             (pht_en),
        .pht_we             (pht_we),
        .pht_local_addr     (pht_local_addr),
        .pht_gshare_addr    (pht_gshare_addr),
        .pht_local_wdata    (pht_local_wdata),
        .pht_gshare_wdata   (pht_gshare_wdata),
        .pht_local_rdata    (pht_local_rdata),
        .pht_gshare_rdata   (pht_gshare_rdata),
        .chooser_we         (chooser_we),
        .chooser_mispredict (chooser_mispredict),
        .chooser_pred_used  (chooser_pred_used),
        .busy               (busy)
`ifdef BP_UPD_STATS_EN
        ,
        .stat_updates       (stat_updates),
        .stat_mispredicts   (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PHT SRAM model: registered read, with a bench-only preload port.
    bit [1:0]   lmem [1024];
    bit [1:0]   gmem [1024];
    logic       pl_en;
    logic [9:0] pl_la, pl_ga;
    logic [1:0] pl_lv, pl_gv;

    typedef struct {
        logic [9:0] la;
        logic [1:0] lw;
        logic [1:0] gw;
    } wr_t;
    wr_t wlog[$];
    int  cw_cnt;

    always @(posedge clk) begin
        if (pl_en) begin
            lmem[pl_la] <= pl_lv;
            gmem[pl_ga] <= pl_gv;
        end else if (pht_en && pht_we) begin
            lmem[pht_local_addr]  <= pht_local_wdata;
            gmem[pht_gshare_addr] <= pht_gshare_wdata;
        end
        if (pht_en && !pht_we) begin
            pht_local_rdata  <= lmem[pht_local_addr];
            pht_gshare_rdata <= gmem[pht_gshare_addr];
        end
        if (pht_en && pht_we)
            wlog.push_back('{pht_local_addr, pht_local_wdata, pht_gshare_wdata});
        if (chooser_we)
            cw_cnt <= cw_cnt + 1;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] la, input logic [1:0] lv,
                           input logic [9:0] ga, input logic [1:0] gv);
        pl_en = 1'b1; pl_la = la; pl_lv = lv; pl_ga = ga; pl_gv = gv;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [9:0] ghr,
                       input logic t, input logic m, input logic u);
        upd_valid = 1'b1; upd_pc = pc; upd_ghr = ghr;
        upd_taken = t; upd_mispredict = m; upd_pred_used = u;
        chk("enq_ready", upd_ready, 1);
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        while (!(pht_en === 1'b1 && pht_we === 1'b1) && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_wr_seen"}, pht_en & pht_we, 1);
    endtask

    task automatic upd_check(input string tag, input logic [31:0] pc, input logic [9:0] ghr,
                             input logic t, input logic m, input logic u,
                             input logic [9:0] la, input logic [9:0] ga,
                             input logic [1:0] lw, input logic [1:0] gw);
        enq(pc, ghr, t, m, u);
        wait_wr(tag);
        chk({tag, "_laddr"}, pht_local_addr, la);
        chk({tag, "_gaddr"}, pht_gshare_addr, ga);
        chk({tag, "_lw"}, pht_local_wdata, lw);
        chk({tag, "_gw"}, pht_gshare_wdata, gw);
        chk({tag, "_cw"}, chooser_we, 1);
        chk({tag, "_cm"}, chooser_mispredict, m);
        chk({tag, "_cu"}, chooser_pred_used, u);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int cwb;
        int n;
        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
        upd_mispredict = 1'b0; upd_pred_used = 1'b0; fe_lookup = 1'b0;
        pl_en = 1'b0; pl_la = '0; pl_ga = '0; pl_lv = '0; pl_gv = '0;
        cw_cnt = 0;
        repeat (3) tick();
        chk("rst_ready", upd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_en", pht_en, 0);
        chk("rst_cw", chooser_we, 0);
        rst = 1'b0;
        tick();

        // Single uncontended update: pc 0x1010 -> local 0x004, gshare 0x004^0x3 = 0x007.
        preload(10'h004, 2'd1, 10'h007, 2'd3);
        enq(32'h0000_1010, 10'h003, 1'b1, 1'b1, 1'b0);
        chk("t1_pop_busy", busy, 1);
        chk("t1_pop_en", pht_en, 0);
        tick();
        chk("t1_rd_en", pht_en, 1);
        chk("t1_rd_we", pht_we, 0);
        chk("t1_rd_laddr", pht_local_addr, 10'h004);
        chk("t1_rd_gaddr", pht_gshare_addr, 10'h007);
        tick();
        chk("t1_wait_en", pht_en, 0);
        tick();
        chk("t1_wr_en", pht_en, 1);
        chk("t1_wr_we", pht_we, 1);
        chk("t1_wr_lw", pht_local_wdata, 2'd2);
        chk("t1_wr_gw", pht_gshare_wdata, 2'd3);
        chk("t1_wr_cw", chooser_we, 1);
        chk("t1_wr_cm", chooser_mispredict, 1);
        chk("t1_wr_cu", chooser_pred_used, 0);
        tick();
        chk("t1_after_cw", chooser_we, 0);
        chk("t1_after_busy", busy, 0);

        // Saturation at both ends.
        preload(10'h000, 2'd0, 10'h015, 2'd2);
        upd_check("nt_sat", 32'h0000_2000, 10'h015, 1'b0, 1'b0, 1'b1, 10'h000, 10'h015, 2'd0, 2'd1);
        preload(10'h3FF, 2'd3, 10'h000, 2'd3);
        upd_check("t_sat", 32'h0000_0FFC, 10'h3FF, 1'b1, 1'b1, 1'b1, 10'h3FF, 10'h000, 2'd3, 2'd3);

        // Front-end contention: two stalled RD cycles and one stalled WR cycle.
        preload(10'h004, 2'd2, 10'h007, 2'd1);
        cwb = cw_cnt;
        enq(32'h0000_1010, 10'h003, 1'b0, 1'b0, 1'b0);
        tick();
        fe_lookup = 1'b1; #1;
        chk("fe_rd0_en", pht_en, 0);
        tick();
        chk("fe_rd1_en", pht_en, 0);
        tick();
        fe_lookup = 1'b0; #1;
        chk("fe_rd_go_en", pht_en, 1);
        chk("fe_rd_go_we", pht_we, 0);
        tick();
        chk("fe_wait_en", pht_en, 0);
        tick();
        fe_lookup = 1'b1; #1;
        chk("fe_wr0_en", pht_en, 0);
        chk("fe_wr0_cw", chooser_we, 0);
        chk("fe_wr0_hold_lw", pht_local_wdata, 2'd1);
        tick();
        fe_lookup = 1'b0; #1;
        chk("fe_wr_we", pht_en & pht_we, 1);
        chk("fe_wr_lw", pht_local_wdata, 2'd1);
        chk("fe_wr_gw", pht_gshare_wdata, 2'd0);
        chk("fe_wr_cw", chooser_we, 1);
        tick();
        chk("fe_after_busy", busy, 0);
        chk("fe_one_pulse", cw_cnt - cwb, 1);

        // Fill: U0 parked in RD by fe_lookup, then four more entries fill the FIFO.
        base = wlog.size();
        enq(32'h0000_0800, 10'h000, 1'b1, 1'b0, 1'b0);
        fe_lookup = 1'b1;
        tick();
        chk("fill_rd_stall", pht_en, 0);
        for (int k = 1; k <= 4; k++)
            enq(32'h40 * k, 10'h000, 1'b1, k[0], 1'b0);
        chk("fill_full_ready", upd_ready, 0);
        upd_valid = 1'b1; upd_pc = 32'h0000_0FC0; upd_ghr = '0;
        tick();
        chk("fill_5th_ready0", upd_ready, 0);
        tick();
        chk("fill_5th_ready1", upd_ready, 0);
        upd_valid = 1'b0;
        fe_lookup = 1'b0; #1;
        chk("fill_u0_read", pht_en, 1);
        tick();
        tick();
        chk("fill_u0_write", pht_en & pht_we, 1);
        tick();
        chk("fill_ready_at_pop", upd_ready, 0);
        tick();
        chk("fill_ready_after_pop", upd_ready, 1);
        n = 0;
        while (wlog.size() < base + 5 && n < 100) begin
            tick();
            n++;
        end
        chk("fill_drained", wlog.size() - base, 5);
        chk("fill_busy_low", busy, 0);
        if (wlog.size() >= base + 5) begin
            chk("fill_order0", wlog[base].la, 10'h200);
            for (int k = 1; k <= 4; k++)
                chk("fill_order", wlog[base + k].la, 10'h010 * k);
        end
        repeat (5) tick();
        chk("fill_no_5th", wlog.size() - base, 5);

        // Same index back-to-back: 1 -> 2 -> 3 in both tables.
        preload(10'h155, 2'd1, 10'h155, 2'd1);
        base = wlog.size();
        enq(32'h0000_0554, 10'h000, 1'b1, 1'b0, 1'b0);
        enq(32'h0000_0554, 10'h000, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (wlog.size() < base + 2 && n < 100) begin
            tick();
            n++;
        end
        chk("same_writes", wlog.size() - base, 2);
        if (wlog.size() >= base + 2) begin
            chk("same_first_lw", wlog[base].lw, 2'd2);
            chk("same_first_gw", wlog[base].gw, 2'd2);
            chk("same_second_lw", wlog[base + 1].lw, 2'd3);
            chk("same_second_gw", wlog[base + 1].gw, 2'd3);
        end
        tick();
`ifdef BP_UPD_STATS_EN
        chk("stat_updates", stat_updates, 11);
        chk("stat_mispredicts", stat_mispredicts, 4);
`endif

        // Reset while in WAIT with two entries queued.
        base = wlog.size();
        cwb = cw_cnt;
        enq(32'h0000_0100, 10'h000, 1'b1, 1'b1, 1'b0);
        enq(32'h0000_0104, 10'h000, 1'b1, 1'b1, 1'b0);
        enq(32'h0000_0108, 10'h000, 1'b1, 1'b1, 1'b0);
        chk("rw_wait_busy", busy, 1);
        chk("rw_wait_en", pht_en, 0);
        rst = 1'b1;
        tick();
        chk("rw_we", pht_we, 0);
        chk("rw_cw", chooser_we, 0);
        chk("rw_busy", busy, 0);
        chk("rw_ready", upd_ready, 1);
`ifdef BP_UPD_STATS_EN
        chk("rw_stat_updates", stat_updates, 0);
        chk("rw_stat_mispredicts", stat_mispredicts, 0);
`endif
        rst = 1'b0;
        repeat (6) tick();
        chk("rw_no_writes", wlog.size() - base, 0);
        chk("rw_no_pulses", cw_cnt - cwb, 0);
        chk("rw_idle_busy", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
